// File: rtl/scrap_controller_if.sv
// Bus bundle between scrap_controller, program/data memory and the alu_and_reg datapath.
// The master side is the controller; the slave side is memory plus datapath.
interface scrap_controller_if;
  logic [15:0] memData;
  logic [15:0] busA;
  logic [4:0]  flags;
  logic [15:0] memAddr;
  logic        memWe;
  logic [7:0]  aluOp;
  logic [4:0]  RegEn;
  logic [4:0]  BufEnA;
  logic [4:0]  BufEnB;
  logic [15:0] imm;
  logic        immEn;
  logic        memReadEn;
  logic        aluResultEn;
  logic        cin;
  logic [15:0] pc;

  modport master (
    input  memData, busA, flags,
    output memAddr, memWe, aluOp, RegEn, BufEnA, BufEnB,
           imm, immEn, memReadEn, aluResultEn, cin, pc
  );

  modport slave (
    output memData, busA, flags,
    input  memAddr, memWe, aluOp, RegEn, BufEnA, BufEnB,
           imm, immEn, memReadEn, aluResultEn, cin, pc
  );
endinterface

// File: rtl/scrap_controller.sv
// Fetch/decode/execute sequencer for the alu_and_reg datapath: holds PC, IR and PSR
// and decodes the current state and instruction into datapath and memory controls.
module scrap_controller (
  input  logic                clk,
  input  logic                reset,
  scrap_controller_if.master  bus
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, LOADWB} state_t;

  localparam logic [4:0] NONE = 5'd16;

  state_t      state, state_nxt;
  logic [15:0] pc_q, pc_nxt;
  logic [15:0] ir;
  logic [4:0]  psr;
  logic        psr_ld;

  logic [3:0] op, rd, ext, rs;
  assign op  = ir[15:12];
  assign rd  = ir[11:8];
  assign ext = ir[7:4];
  assign rs  = ir[3:0];

  logic [15:0] mem_addr, imm_val;
  logic [7:0]  alu_op;
  logic [4:0]  reg_en, buf_a, buf_b;
  logic        mem_we, imm_en, mem_read_en, alu_res_en, carry_in;

  function automatic logic signed [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  // PSR bit order: [0] C, [1] L, [2] F, [3] Z, [4] N
  function automatic logic cond_taken(input logic [3:0] c, input logic [4:0] p);
    logic t;
    case (c)
      4'h0:    t = p[3];
      4'h1:    t = !p[3];
      4'h2:    t = p[0];
      4'h3:    t = !p[0];
      4'h4:    t = p[1];
      4'h5:    t = !p[1];
      4'h6:    t = p[4];
      4'h7:    t = !p[4];
      4'h8:    t = p[2];
      4'h9:    t = !p[2];
      4'hE:    t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc_q  <= '0;
      ir    <= '0;
      psr   <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      if (state == DECODE) ir <= bus.memData;
      if (psr_ld) psr <= bus.flags;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    psr_ld      = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    alu_op      = '0;
    reg_en      = NONE;
    buf_a       = NONE;
    buf_b       = NONE;
    imm_val     = '0;
    imm_en      = 1'b0;
    mem_read_en = 1'b0;
    alu_res_en  = 1'b0;
    carry_in    = 1'b0;

    case (state)
      FETCH: begin
        mem_addr  = pc_q;
        state_nxt = DECODE;
      end
      DECODE: begin
        mem_addr  = pc_q;
        pc_nxt    = pc_q + 16'd1;
        state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = FETCH;
        case (op)
          4'h0: begin
            alu_op     = {4'h0, ext};
            buf_a      = {1'b0, rd};
            buf_b      = {1'b0, rs};
            alu_res_en = 1'b1;
            reg_en     = (ext == 4'hB) ? NONE : {1'b0, rd};
            carry_in   = (ext == 4'h7) && psr[0];
            psr_ld     = 1'b1;
          end
          // Immediate ALU ops write through the ALU result path like RR ops
          4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD: begin
            alu_op     = {op, 4'h0};
            buf_a      = {1'b0, rd};
            imm_en     = 1'b1;
            imm_val    = $unsigned(sext8(ir[7:0]));
            alu_res_en = 1'b1;
            reg_en     = (op == 4'hB) ? NONE : {1'b0, rd};
            carry_in   = (op == 4'h7) && psr[0];
            psr_ld     = 1'b1;
          end
          4'h4: begin
            case (ext)
              4'h0: begin
                mem_addr  = bus.busA;
                buf_a     = {1'b0, rs};
                state_nxt = LOADWB;
              end
              4'h4: begin
                mem_addr = bus.busA;
                buf_a    = {1'b0, rs};
                buf_b    = {1'b0, rd};
                mem_we   = 1'b1;
              end
              // pc_q is already incremented here, so it is the link value
              4'h8: begin
                imm_val    = pc_q;
                imm_en     = 1'b1;
                alu_op     = 8'h0D;
                alu_res_en = 1'b1;
                reg_en     = {1'b0, rd};
                buf_a      = {1'b0, rs};
                pc_nxt     = bus.busA;
              end
              4'hC: begin
                buf_a = {1'b0, rs};
                if (cond_taken(rd, psr)) pc_nxt = bus.busA;
              end
              default: ;
            endcase
          end
          4'hC: begin
            if (cond_taken(rd, psr)) pc_nxt = pc_q + $unsigned(sext8(ir[7:0]));
          end
          default: ;
        endcase
      end
      LOADWB: begin
        mem_read_en = 1'b1;
        reg_en      = {1'b0, rd};
        state_nxt   = FETCH;
      end
      default: state_nxt = FETCH;
    endcase

    // Reset forces idle outputs so no write of any kind lands in a reset cycle
    if (reset) begin
      mem_addr    = '0;
      mem_we      = 1'b0;
      alu_op      = '0;
      reg_en      = NONE;
      buf_a       = NONE;
      buf_b       = NONE;
      imm_val     = '0;
      imm_en      = 1'b0;
      mem_read_en = 1'b0;
      alu_res_en  = 1'b0;
      carry_in    = 1'b0;
    end
  end

  assign bus.memAddr     = mem_addr;
  assign bus.memWe       = mem_we;
  assign bus.aluOp       = alu_op;
  assign bus.RegEn       = reg_en;
  assign bus.BufEnA      = buf_a;
  assign bus.BufEnB      = buf_b;
  assign bus.imm         = imm_val;
  assign bus.immEn       = imm_en;
  assign bus.memReadEn   = mem_read_en;
  assign bus.aluResultEn = alu_res_en;
  assign bus.cin         = carry_in;
  assign bus.pc          = reset ? 16'h0000 : pc_q;

  imm_excl_a: assert property (@(posedge clk) disable iff (reset) imm_en |-> (buf_b == NONE));
  src_excl_a: assert property (@(posedge clk) disable iff (reset) !(mem_read_en && alu_res_en));
endmodule
